// File: rtl/sniff_shift_window.sv
// rtl/sniff_shift_window.sv - DEPTH-stage tagged shift window with occupancy, eviction and numeric-run tracking
// Optional numeric-run counter is enabled by defining SNIFF_NUM_RUN_EN.
module sniff_shift_window #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int TAG_W  = 2,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      flush,
  input  logic                      in_valid,
  input  logic [DATA_W-1:0]         data_in,
  input  logic [TAG_W-1:0]          tag_in,
  output logic [DEPTH*DATA_W-1:0]   win_data,
  output logic [DEPTH*TAG_W-1:0]    win_tag,
  output logic [DEPTH-1:0]          win_valid,
  output logic [CNT_W-1:0]          fill_cnt,
  output logic                      win_full,
  output logic                      evict_valid,
  output logic [DATA_W-1:0]         evict_data,
  output logic [TAG_W-1:0]          evict_tag,
  output logic [CNT_W-1:0]          num_run
);

  // Stage k lives at slice k of each packed vector, stage 0 newest.
  logic [DEPTH*DATA_W-1:0] data_q, data_d;
  logic [DEPTH*TAG_W-1:0]  tag_q, tag_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [CNT_W-1:0]        fill_q, fill_d;
  logic                    evict_valid_q, evict_valid_d;
  logic [DATA_W-1:0]       evict_data_q, evict_data_d;
  logic [TAG_W-1:0]        evict_tag_q, evict_tag_d;

  // Next-state for window, occupancy and eviction: flush beats shift beats hold.
  always_comb begin
    data_d        = data_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    fill_d        = fill_q;
    evict_valid_d = 1'b0;
    evict_data_d  = evict_data_q;
    evict_tag_d   = evict_tag_q;
    if (flush) begin
      data_d  = '0;
      tag_d   = '0;
      valid_d = '0;
      fill_d  = '0;
    end else if (en) begin
      data_d        = {data_q[(DEPTH-1)*DATA_W-1:0], data_in};
      tag_d         = {tag_q[(DEPTH-1)*TAG_W-1:0], tag_in};
      valid_d       = {valid_q[DEPTH-2:0], in_valid};
      fill_d        = fill_q + CNT_W'(in_valid) - CNT_W'(valid_q[DEPTH-1]);
      evict_valid_d = valid_q[DEPTH-1];
      // Bubbles leaving the last stage do not disturb the held eviction word.
      if (valid_q[DEPTH-1]) begin
        evict_data_d = data_q[(DEPTH-1)*DATA_W +: DATA_W];
        evict_tag_d  = tag_q[(DEPTH-1)*TAG_W +: TAG_W];
      end
    end
  end

  // Window and eviction registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q        <= '0;
      tag_q         <= '0;
      valid_q       <= '0;
      fill_q        <= '0;
      evict_valid_q <= 1'b0;
      evict_data_q  <= '0;
      evict_tag_q   <= '0;
    end else begin
      data_q        <= data_d;
      tag_q         <= tag_d;
      valid_q       <= valid_d;
      fill_q        <= fill_d;
      evict_valid_q <= evict_valid_d;
      evict_data_q  <= evict_data_d;
      evict_tag_q   <= evict_tag_d;
    end
  end

  // Occupancy can never wrap: it always equals the number of set valid bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones(valid_q) == int'(fill_q));
      assert (!(en && !flush && fill_q == CNT_W'(DEPTH) && in_valid && !valid_q[DEPTH-1]));
      assert (!(en && !flush && fill_q == '0 && !in_valid && valid_q[DEPTH-1]));
    end
  end

`ifdef SNIFF_NUM_RUN_EN
  logic [CNT_W-1:0] num_run_q, num_run_d;

  // Run length of numeric characters ending at stage 0, saturating at DEPTH.
  always_comb begin
    num_run_d = num_run_q;
    if (flush) begin
      num_run_d = '0;
    end else if (en) begin
      if (in_valid && tag_in[0]) begin
        num_run_d = (num_run_q == CNT_W'(DEPTH)) ? num_run_q : num_run_q + CNT_W'(1);
      end else begin
        num_run_d = '0;
      end
    end
  end

  // Numeric-run register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_run_q <= '0;
    end else begin
      num_run_q <= num_run_d;
    end
  end

  assign num_run = num_run_q;
`else
  assign num_run = '0;
`endif

  assign win_data    = data_q;
  assign win_tag     = tag_q;
  assign win_valid   = valid_q;
  assign fill_cnt    = fill_q;
  assign win_full    = (fill_q == CNT_W'(DEPTH));
  assign evict_valid = evict_valid_q;
  assign evict_data  = evict_data_q;
  assign evict_tag   = evict_tag_q;

endmodule

// File: tb/tb_sniff_shift_window.sv
// tb/tb_sniff_shift_window.sv - randomized self-checking bench for sniff_shift_window against an array model
module tb_sniff_shift_window;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int TAG_W  = 2;
  localparam int CNT_W  = 4;
  localparam int SW = DEPTH*DATA_W + DEPTH*TAG_W + DEPTH + CNT_W + 2 + DATA_W + TAG_W + CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [TAG_W-1:0]  tag_in = '0;
  logic [DEPTH*DATA_W-1:0] win_data;
  logic [DEPTH*TAG_W-1:0]  win_tag;
  logic [DEPTH-1:0]        win_valid;
  logic [CNT_W-1:0]        fill_cnt;
  logic                    win_full, evict_valid;
  logic [DATA_W-1:0]       evict_data;
  logic [TAG_W-1:0]        evict_tag;
  logic [CNT_W-1:0]        num_run;

  sniff_shift_window dut (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid),
    .data_in(data_in), .tag_in(tag_in), .win_data(win_data), .win_tag(win_tag),
    .win_valid(win_valid), .fill_cnt(fill_cnt), .win_full(win_full),
    .evict_valid(evict_valid), .evict_data(evict_data), .evict_tag(evict_tag),
    .num_run(num_run)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the window as a plain array of characters.
  logic [7:0] m_data [DEPTH];
  logic [1:0] m_tag  [DEPTH];
  logic       m_valid[DEPTH];
  logic       m_ev_valid;
  logic [7:0] m_ev_data;
  logic [1:0] m_ev_tag;
  int         m_run;

  logic [SW-1:0] act_snap;
  assign act_snap = {win_data, win_tag, win_valid, fill_cnt, win_full,
                     evict_valid, evict_data, evict_tag, num_run};

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0; m_tag[i] = '0; m_valid[i] = 1'b0;
    end
    m_ev_valid = 1'b0;
    m_run = 0;
  endtask

  task automatic model_reset();
    model_clear();
    m_ev_data = '0;
    m_ev_tag = '0;
  endtask

  task automatic model_step(input logic e, input logic f, input logic v,
                            input logic [7:0] d, input logic [1:0] t);
    if (f) begin
      model_clear();
    end else if (e) begin
      m_ev_valid = m_valid[DEPTH-1];
      if (m_valid[DEPTH-1]) begin
        m_ev_data = m_data[DEPTH-1];
        m_ev_tag  = m_tag[DEPTH-1];
      end
      for (int i = DEPTH-1; i > 0; i--) begin
        m_data[i] = m_data[i-1]; m_tag[i] = m_tag[i-1]; m_valid[i] = m_valid[i-1];
      end
      m_data[0] = d; m_tag[0] = t; m_valid[0] = v;
      m_run = (v && t[0]) ? ((m_run >= DEPTH) ? DEPTH : m_run + 1) : 0;
    end else begin
      m_ev_valid = 1'b0;
    end
  endtask

  function automatic logic [SW-1:0] exp_snap();
    logic [DEPTH*DATA_W-1:0] d;
    logic [DEPTH*TAG_W-1:0]  t;
    logic [DEPTH-1:0]        v;
    int fill;
    logic [CNT_W-1:0] run;
    fill = 0;
    for (int k = 0; k < DEPTH; k++) begin
      d[k*DATA_W +: DATA_W] = m_data[k];
      t[k*TAG_W +: TAG_W]   = m_tag[k];
      v[k] = m_valid[k];
      if (m_valid[k]) fill++;
    end
`ifdef SNIFF_NUM_RUN_EN
    run = CNT_W'(m_run);
`else
    run = '0;
`endif
    return {d, t, v, CNT_W'(fill), (fill == DEPTH), m_ev_valid, m_ev_data, m_ev_tag, run};
  endfunction

  task automatic drive(input logic e, input logic f, input logic v,
                       input logic [7:0] d, input logic [1:0] t);
    en = e; flush = f; in_valid = v; data_in = d; tag_in = t;
    @(posedge clk);
    model_step(e, f, v, d, t);
    #1;
  endtask

  task automatic test_reset();
    model_reset();
    #2;
    n_tests++;
    if (act_snap !== exp_snap()) begin
      n_fail++; $display("FAIL reset_state act=%h exp=%h", act_snap, exp_snap());
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00, 2'b00);
    n_tests++;
    if (act_snap !== exp_snap()) begin
      n_fail++; $display("FAIL reset_idle act=%h exp=%h", act_snap, exp_snap());
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h31 + 8'(i), 2'b01);
      n_tests++;
      if (act_snap !== exp_snap()) begin
        n_fail++; $display("FAIL fill_step%0d act=%h exp=%h", i, act_snap, exp_snap());
      end
      n_tests++;
      if (evict_valid !== 1'b0) begin
        n_fail++; $display("FAIL fill_no_evict%0d act=%b exp=0", i, evict_valid);
      end
    end
    n_tests++;
    if ({win_full, win_data[7:0], win_data[63:56]} !== {1'b1, 8'h38, 8'h31}) begin
      n_fail++; $display("FAIL fill_full act=%b/%h/%h exp=1/38/31", win_full, win_data[7:0], win_data[63:56]);
    end
  endtask

  task automatic test_evict();
    drive(1'b1, 1'b0, 1'b1, 8'h39, 2'b01);
    n_tests++;
    if ({evict_valid, evict_data, fill_cnt} !== {1'b1, 8'h31, 4'd8}) begin
      n_fail++; $display("FAIL evict_first act=%b/%h/%0d exp=1/31/8", evict_valid, evict_data, fill_cnt);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 1'b1, 8'hAA, 2'b11);
      n_tests++;
      if (evict_valid !== 1'b0 || act_snap !== exp_snap()) begin
        n_fail++; $display("FAIL evict_hold%0d act=%h exp=%h", i, act_snap, exp_snap());
      end
    end
  endtask

  task automatic test_bubble();
    drive(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
    drive(1'b1, 1'b0, 1'b1, 8'h41, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 8'h7E, 2'b10);
    drive(1'b1, 1'b0, 1'b1, 8'h42, 2'b00);
    n_tests++;
    if ({win_valid[2:0], fill_cnt} !== {3'b101, 4'd2}) begin
      n_fail++; $display("FAIL bubble_valid act=%b/%0d exp=101/2", win_valid[2:0], fill_cnt);
    end
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0, 1'b1, 8'h60 + 8'(i), 2'(i));
      n_tests++;
      if (act_snap !== exp_snap()) begin
        n_fail++; $display("FAIL bubble_step%0d act=%h exp=%h", i, act_snap, exp_snap());
      end
    end
    n_tests++;
    if (evict_valid !== 1'b0) begin
      n_fail++; $display("FAIL bubble_no_evict act=%b exp=0", evict_valid);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, 1'b1, 8'h55, 2'b11);
    n_tests++;
    if ({win_valid, fill_cnt, win_data} !== '0) begin
      n_fail++; $display("FAIL flush_clear act=%b/%0d/%h exp=0/0/0", win_valid, fill_cnt, win_data);
    end
    n_tests++;
    if (act_snap !== exp_snap()) begin
      n_fail++; $display("FAIL flush_snap act=%h exp=%h", act_snap, exp_snap());
    end
  endtask

  task automatic test_num_run();
    logic [7:0] chars [6];
    int exp_run [6];
    int cap;
    chars = '{8'h31, 8'h32, 8'h61, 8'h33, 8'h34, 8'h35};
`ifdef SNIFF_NUM_RUN_EN
    exp_run = '{1, 2, 0, 1, 2, 3};
    cap = DEPTH;
`else
    exp_run = '{0, 0, 0, 0, 0, 0};
    cap = 0;
`endif
    drive(1'b0, 1'b1, 1'b0, 8'h00, 2'b00);
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, chars[i], (chars[i] < 8'h40) ? 2'b01 : 2'b00);
      n_tests++;
      if (int'(num_run) !== exp_run[i]) begin
        n_fail++; $display("FAIL num_run_str%0d act=%0d exp=%0d", i, num_run, exp_run[i]);
      end
    end
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b1, 8'h30 + 8'(i), 2'b01);
    n_tests++;
    if (int'(num_run) !== cap || act_snap !== exp_snap()) begin
      n_fail++; $display("FAIL num_run_cap act=%0d exp=%0d", num_run, cap);
    end
    drive(1'b1, 1'b0, 1'b0, 8'h39, 2'b01);
    n_tests++;
    if (num_run !== 4'd0) begin
      n_fail++; $display("FAIL num_run_bubble act=%0d exp=0", num_run);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) != 0, 8'($urandom), 2'($urandom_range(0, 3)));
      n_tests++;
      if (act_snap !== exp_snap()) begin
        n_fail++; $display("FAIL random_step%0d act=%h exp=%h", i, act_snap, exp_snap());
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < DEPTH + 2; i++) drive(1'b1, 1'b0, 1'b1, 8'(8'hC0 + i), 2'b01);
    n_tests++;
    if (win_full !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_prefull act=%b exp=1", win_full);
    end
    en = 1'b1; in_valid = 1'b1; data_in = 8'hEE;
    #2 rst = 1'b1;
    model_reset();
    #1;
    n_tests++;
    if (act_snap !== exp_snap()) begin
      n_fail++; $display("FAIL rst_mid_async act=%h exp=%h", act_snap, exp_snap());
    end
    @(posedge clk); #1;
    n_tests++;
    if (act_snap !== exp_snap() || fill_cnt !== 4'd0) begin
      n_fail++; $display("FAIL rst_mid_next act=%h exp=%h", act_snap, exp_snap());
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 8'h12, 2'b01);
    n_tests++;
    if (act_snap !== exp_snap()) begin
      n_fail++; $display("FAIL rst_mid_resume act=%h exp=%h", act_snap, exp_snap());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fill();
    test_evict();
    test_bubble();
    test_flush();
    test_num_run();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
